// File: rtl/sc_fifo_ram.sv
// Simple dual-port storage for sc_fifo_core: one write port and one registered read port.
// Kept separate so synthesis can map it to block RAM or distributed RAM per instance.
module sc_fifo_ram #(
  parameter int WIDTH  = 17,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  q
);

  logic [WIDTH-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; the array contents are don't-care after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (re) begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/sc_fifo_core.sv
// Parameterized single-clock FIFO with read-side and write-side status views.
// Both views are driven from one set of registers since there is only one clock.
module sc_fifo_core #(
  parameter int WIDTH      = 17,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [WIDTH-1:0]      q,
  output logic                  rdempty,
  output logic                  rdfull,
  output logic [DEPTH_LOG2:0]   rdusedw,
  output logic                  wrempty,
  output logic                  wrfull,
  output logic [DEPTH_LOG2:0]   wrusedw
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [PW-1:0] wptr, rptr;
  logic [PW-1:0] wptr_nxt, rptr_nxt, count_nxt;
  logic [PW-1:0] usedw_r;
  logic          empty_r, full_r;
  logic          wr_acc, rd_acc;

  // Requests are qualified by the registered flags, so a write into a full FIFO
  // is dropped even when a read frees a slot on the same edge (and vice versa).
  always_comb begin
    wr_acc    = wrreq & ~full_r;
    rd_acc    = rdreq & ~empty_r;
    wptr_nxt  = wptr + {{(PW-1){1'b0}}, wr_acc};
    rptr_nxt  = rptr + {{(PW-1){1'b0}}, rd_acc};
    count_nxt = wptr_nxt - rptr_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      usedw_r <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      usedw_r <= count_nxt;
      empty_r <= (count_nxt == '0);
      full_r  <= (count_nxt == PW'(DEPTH));
    end
  end

  sc_fifo_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wptr[DEPTH_LOG2-1:0]),
    .wdata (data),
    .re    (rd_acc),
    .raddr (rptr[DEPTH_LOG2-1:0]),
    .q     (q)
  );

  assign rdempty = empty_r;
  assign wrempty = empty_r;
  assign rdfull  = full_r;
  assign wrfull  = full_r;
  assign rdusedw = usedw_r;
  assign wrusedw = usedw_r;

endmodule

// File: tb/tb_sc_fifo_core.sv
// Self-checking bench for sc_fifo_core: three instances (17x64, 528x32, 80x64) checked
// against queue-based reference models driven by directed and $urandom stimulus.
module tb_sc_fifo_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: WIDTH=17, DEPTH_LOG2=6
  logic [16:0] a_data = '0, a_q;
  logic        a_wrreq = 1'b0, a_rdreq = 1'b0;
  logic        a_rdempty, a_rdfull, a_wrempty, a_wrfull;
  logic [6:0]  a_rdusedw, a_wrusedw;
  logic [16:0] a_mdl[$];
  logic [16:0] a_exp_q = '0;

  // Instance B: WIDTH=528, DEPTH_LOG2=5
  logic [527:0] b_data = '0, b_q;
  logic         b_wrreq = 1'b0, b_rdreq = 1'b0;
  logic         b_rdempty, b_rdfull, b_wrempty, b_wrfull;
  logic [5:0]   b_rdusedw, b_wrusedw;
  logic [527:0] b_mdl[$];
  logic [527:0] b_exp_q = '0;

  // Instance C: WIDTH=80, DEPTH_LOG2=6
  logic [79:0] c_data = '0, c_q;
  logic        c_wrreq = 1'b0, c_rdreq = 1'b0;
  logic        c_rdempty, c_rdfull, c_wrempty, c_wrfull;
  logic [6:0]  c_rdusedw, c_wrusedw;
  logic [79:0] c_mdl[$];
  logic [79:0] c_exp_q = '0;

  sc_fifo_core #(.WIDTH(17), .DEPTH_LOG2(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .data(a_data), .wrreq(a_wrreq), .rdreq(a_rdreq), .q(a_q),
    .rdempty(a_rdempty), .rdfull(a_rdfull), .rdusedw(a_rdusedw),
    .wrempty(a_wrempty), .wrfull(a_wrfull), .wrusedw(a_wrusedw)
  );

  sc_fifo_core #(.WIDTH(528), .DEPTH_LOG2(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .data(b_data), .wrreq(b_wrreq), .rdreq(b_rdreq), .q(b_q),
    .rdempty(b_rdempty), .rdfull(b_rdfull), .rdusedw(b_rdusedw),
    .wrempty(b_wrempty), .wrfull(b_wrfull), .wrusedw(b_wrusedw)
  );

  sc_fifo_core #(.WIDTH(80), .DEPTH_LOG2(6)) dut_c (
    .clk(clk), .rst_n(rst_n), .data(c_data), .wrreq(c_wrreq), .rdreq(c_rdreq), .q(c_q),
    .rdempty(c_rdempty), .rdfull(c_rdfull), .rdusedw(c_rdusedw),
    .wrempty(c_wrempty), .wrfull(c_wrfull), .wrusedw(c_wrusedw)
  );

  task automatic checkOutput(input string tag, input logic [527:0] obs, input logic [527:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkA();
    int n;
    n = a_mdl.size();
    checkOutput("a_q", a_q, a_exp_q);
    checkOutput("a_rdusedw", a_rdusedw, n);
    checkOutput("a_wrusedw", a_wrusedw, n);
    checkOutput("a_rdempty", a_rdempty, n == 0);
    checkOutput("a_wrempty", a_wrempty, n == 0);
    checkOutput("a_rdfull", a_rdfull, n == 64);
    checkOutput("a_wrfull", a_wrfull, n == 64);
  endtask

  task automatic checkB();
    int n;
    n = b_mdl.size();
    checkOutput("b_q", b_q, b_exp_q);
    checkOutput("b_rdusedw", b_rdusedw, n);
    checkOutput("b_wrusedw", b_wrusedw, n);
    checkOutput("b_usedw_le_32", b_wrusedw <= 6'd32, 1'b1);
    checkOutput("b_empty", {b_rdempty, b_wrempty}, (n == 0) ? 2'b11 : 2'b00);
    checkOutput("b_full", {b_rdfull, b_wrfull}, (n == 32) ? 2'b11 : 2'b00);
  endtask

  task automatic checkC();
    int n;
    n = c_mdl.size();
    checkOutput("c_q", c_q, c_exp_q);
    checkOutput("c_usedw", {c_rdusedw, c_wrusedw}, {7'(n), 7'(n)});
    checkOutput("c_empty", {c_rdempty, c_wrempty}, (n == 0) ? 2'b11 : 2'b00);
    checkOutput("c_full", {c_rdfull, c_wrfull}, (n == 64) ? 2'b11 : 2'b00);
  endtask

  // One clock of traffic on A: the model decides acceptance from its pre-edge occupancy.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [16:0] d);
    bit wr_ok, rd_ok;
    wr_ok = wr && (a_mdl.size() < 64);
    rd_ok = rd && (a_mdl.size() > 0);
    a_data = d; a_wrreq = wr; a_rdreq = rd;
    @(posedge clk);
    if (rd_ok) a_exp_q = a_mdl.pop_front();
    if (wr_ok) a_mdl.push_back(d);
    #1;
    a_wrreq = 1'b0; a_rdreq = 1'b0;
    checkA();
  endtask

  task automatic applyStimulusB(input bit wr, input bit rd, input logic [527:0] d);
    bit wr_ok, rd_ok;
    wr_ok = wr && (b_mdl.size() < 32);
    rd_ok = rd && (b_mdl.size() > 0);
    b_data = d; b_wrreq = wr; b_rdreq = rd;
    @(posedge clk);
    if (rd_ok) b_exp_q = b_mdl.pop_front();
    if (wr_ok) b_mdl.push_back(d);
    #1;
    b_wrreq = 1'b0; b_rdreq = 1'b0;
    checkB();
  endtask

  task automatic applyStimulusC(input bit wr, input bit rd, input logic [79:0] d);
    bit wr_ok, rd_ok;
    wr_ok = wr && (c_mdl.size() < 64);
    rd_ok = rd && (c_mdl.size() > 0);
    c_data = d; c_wrreq = wr; c_rdreq = rd;
    @(posedge clk);
    if (rd_ok) c_exp_q = c_mdl.pop_front();
    if (wr_ok) c_mdl.push_back(d);
    #1;
    c_wrreq = 1'b0; c_rdreq = 1'b0;
    checkC();
  endtask

  function automatic logic [527:0] rand528();
    logic [527:0] v;
    v = '0;
    for (int i = 0; i < 17; i++) v = {v[495:0], 32'($urandom)};
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [79:0] pat;
    int bias;
    int written;

    repeat (3) @(posedge clk);
    #1;
    checkA();
    checkB();
    checkC();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkA();

    // Three writes then three reads
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b0, 17'(i));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, '0);

    // Fill to full, overflow attempt, simultaneous ops at full
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 1'b0, 17'(i));
    applyStimulus(1'b1, 1'b0, 17'h1FFFF);
    applyStimulus(1'b1, 1'b1, 17'h1FFFF);
    checkOutput("a_full_rw_usedw", a_wrusedw, 7'd63);
    checkOutput("a_full_rw_q", a_q, 17'd0);
    for (int i = 0; i < 63; i++) applyStimulus(1'b0, 1'b1, '0);

    // Simultaneous ops at empty: write wins, read dropped
    applyStimulus(1'b1, 1'b1, 17'h0ABCD);
    checkOutput("a_empty_rw_usedw", a_rdusedw, 7'd1);
    checkOutput("a_empty_rw_q", a_q, 17'd63);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("a_empty_rw_readback", a_q, 17'h0ABCD);

    // Randomized traffic with phases biased toward filling and draining
    for (int i = 0; i < 600; i++) begin
      bias = ((i / 100) % 2 == 0) ? 80 : 20;
      applyStimulus($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias,
                    17'($urandom));
    end

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 17'($urandom));
    applyStimulus(1'b0, 1'b1, '0);
    a_wrreq = 1'b1; a_rdreq = 1'b1; a_data = 17'h15555;
    #2;
    rst_n = 1'b0;
    #1;
    a_mdl.delete();
    a_exp_q = '0;
    checkA();
    a_wrreq = 1'b0; a_rdreq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkA();

    // B: prime, then stream with concurrent read/write across several wraps, then drain
    written = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulusB(1'b1, 1'b0, rand528());
      written++;
    end
    while (written < 100) begin
      applyStimulusB(1'b1, 1'b1, rand528());
      written++;
    end
    for (int i = 0; i < 12; i++) applyStimulusB(1'b0, 1'b1, '0);
    for (int i = 0; i < 300; i++)
      applyStimulusB($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, rand528());
    for (int i = 0; i < 40; i++) applyStimulusB(1'b0, 1'b1, '0);

    // C: reads while empty must not disturb q or pointers
    pat = {10{8'hA5}};
    applyStimulusC(1'b0, 1'b1, '0);
    applyStimulusC(1'b0, 1'b1, '0);
    applyStimulusC(1'b1, 1'b0, pat);
    applyStimulusC(1'b0, 1'b1, '0);
    checkOutput("c_pattern", c_q, pat);
    for (int i = 0; i < 200; i++)
      applyStimulusC($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                     {16'($urandom), 32'($urandom), 32'($urandom)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
